// File: rtl/rca_nibble_seq_if.sv
// ---------------------------------------------------------------------------
// Module      : rca_nibble_seq_if
// Description : Requester-side handshake and operand/result bundle for the
//               slice-serial adder sequencer.
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface rca_nibble_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;

    modport master (
        output start, abort, a, b, ci,
        input  busy, done, s, co
    );

    modport slave (
        input  start, abort, a, b, ci,
        output busy, done, s, co
    );
endinterface

`default_nettype wire

// File: rtl/rca_nibble_seq.sv
// ---------------------------------------------------------------------------
// Module      : rca_nibble_seq
// Description : Computes a WIDTH-bit a+b+ci over NSL cycles through one
//               SLICE-bit ripple-carry slice, least-significant slice first.
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rca_slice #(
    parameter int W = 4
) (
    input  wire logic [W-1:0] i_a,
    input  wire logic [W-1:0] i_b,
    input  wire logic         i_ci,
    output logic      [W-1:0] o_sum,
    output logic              o_co
);
    logic [W:0] w_c;

    assign w_c[0] = i_ci;

    generate
        for (genvar i = 0; i < W; i++) begin : g_fa
            assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    endgenerate

    assign o_co = w_c[W];
endmodule

module rca_nibble_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    rca_nibble_seq_if.slave   bus
);
    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(NSL - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE-1:0] w_sum_sl;
    logic             w_c_sl;

    always_comb begin
        w_a_sl = a_q[cnt_q * SLICE +: SLICE];
        w_b_sl = b_q[cnt_q * SLICE +: SLICE];
    end

    rca_slice #(.W(SLICE)) u_rca4 (
        .i_a   (w_a_sl),
        .i_b   (w_b_sl),
        .i_ci  (carry_q),
        .o_sum (w_sum_sl),
        .o_co  (w_c_sl)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;

        case (state_q)
            ST_RUN: begin
                // Abort takes priority even over the final slice: no done pulse.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    s_d     = '0;
                    co_d    = 1'b0;
                end else begin
                    s_d[cnt_q * SLICE +: SLICE] = w_sum_sl;
                    carry_d = w_c_sl;
                    if (cnt_q == C_CNT_LAST) begin
                        co_d    = w_c_sl;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.ci;
                    cnt_d   = '0;
                    s_d     = '0;
                    co_d    = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;
endmodule

`default_nettype wire
